mux_rr_arbiter: RTL and testbench

// - Shares one N:1 mux datapath between N valid/ready requesters, using round-robin arbitration.
// - Drives the mux select and registers the selected beat into one output stage.
// - Output stage has valid/ready backpressure.
// - Sits in front of any shared single-consumer resource. Sustains one beat per clock.
//

---
 rtl/mux_rr_arbiter.sv | 145 ++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter feeding a shared N:1 mux into one registered output stage.
// The output stage has valid/ready backpressure and sustains one beat per clock.
// Optional burst locking is enabled by defining MUX_ARB_BURST_EN, which adds the
// in_last port.
module mux_rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*W-1:0]     in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
`ifdef MUX_ARB_BURST_EN
  ,
  input  logic [N-1:0]       in_last
`endif
);

  typedef enum logic {StEmpty, StFull} out_state_e;

  out_state_e       state_q, state_d;
  logic [W-1:0]     data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [SEL_W-1:0] win;
  logic [SEL_W-1:0] win_next;
  logic             found;
  logic             can_load;
  logic             fire;
  logic [N-1:0]     grant;
  logic [W-1:0]     win_data;

`ifdef MUX_ARB_BURST_EN
  logic             lock_q, lock_d;
  logic [SEL_W-1:0] lock_idx_q, lock_idx_d;
`endif

  // Arbitration: first valid requester at or after ptr, wrapping; a burst lock overrides.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int unsigned p = 0; p < N; p++) begin
      idx = int'(ptr_q) + p;
      if (idx >= N) idx = idx - N;
      if (!found && in_valid[idx[SEL_W-1:0]]) begin
        found = 1'b1;
        win   = idx[SEL_W-1:0];
      end
    end
`ifdef MUX_ARB_BURST_EN
    // While locked only the burst owner may be granted, even if it drops valid.
    if (lock_q) begin
      found = 1'b1;
      win   = lock_idx_q;
    end
`endif
    can_load = (state_q == StEmpty) || out_ready;
    grant    = '0;
    // rst_n gating keeps every ready low while reset is held.
    if (found && can_load && rst_n) grant[win] = 1'b1;
    fire     = |(grant & in_valid);
    win_next = (win == SEL_W'(N - 1)) ? '0 : win + 1'b1;
  end

  // Datapath mux: select the winning requester's data slice.
  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (win == SEL_W'(i)) win_data = in_data[i*W +: W];
    end
  end

  // Output stage next state, pointer advance and burst lock tracking.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
`ifdef MUX_ARB_BURST_EN
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
`endif
    unique case (state_q)
      StEmpty: if (fire) state_d = StFull;
      StFull:  if (out_ready && !fire) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
    if (fire) begin
      data_d = win_data;
      sel_d  = win;
`ifdef MUX_ARB_BURST_EN
      if (in_last[win]) begin
        lock_d = 1'b0;
        ptr_d  = win_next;
      end else begin
        lock_d     = 1'b1;
        lock_idx_d = win;
      end
`else
      ptr_d = win_next;
`endif
    end
  end

  // State registers; async reset discards any beat held in the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
`ifdef MUX_ARB_BURST_EN
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
`ifdef MUX_ARB_BURST_EN
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
`endif
    end
  end

  // Outputs straight from the registered stage and the grant vector.
  always_comb begin
    in_ready  = grant;
    out_valid = (state_q == StFull);
    out_data  = data_q;
    out_sel   = sel_q;
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (N=4, W=8) with a scoreboard of expected beats.
module tb_mux_rr_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_ready;
`ifdef MUX_ARB_BURST_EN
  logic [N-1:0]   in_last;
`endif

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;

  mux_rr_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef MUX_ARB_BURST_EN
    ,
    .in_last   (in_last)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] sel, input logic [7:0] data);
    beat_t b;
    b.sel  = sel;
    b.data = data;
    sb.push_back(b);
  endtask

  // Sample at the falling edge; a beat leaving the output stage is scoreboarded.
  task automatic cycle();
    beat_t b;
    @(negedge clk);
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      chk("sb_has_entry", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        b = sb.pop_front();
        chk("beat_sel", out_sel, b.sel);
        chk("beat_data", out_data, b.data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    out_ready = 1'b0;
`ifdef MUX_ARB_BURST_EN
    in_last   = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle after reset.
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("idle_out_valid", out_valid, 0);
      chk("idle_out_data", out_data, 0);
      chk("idle_out_sel", out_sel, 0);
      chk("idle_in_ready", in_ready, 0);
    end

    // All requesting, no backpressure: 0,1,2,3,0 back to back.
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    chk("rr_first_ready", in_ready, 4'b0001);
    push(2'd0, 8'hA0);
    push(2'd1, 8'hA1);
    push(2'd2, 8'hA2);
    push(2'd3, 8'hA3);
    push(2'd0, 8'hA0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rr_no_bubble", out_valid, 1);
    end

    // Stall with beat (0, A0) held.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_valid", out_valid, 1);
      chk("stall_sel", out_sel, 0);
      chk("stall_data", out_data, 8'hA0);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("release_ready", in_ready, 4'b0010);
    push(2'd1, 8'hA1);
    cycle();

    // Wrap: grant 2 moves ptr to 3, then 0001 grants 0, then 1001 grants 3 then 0.
    in_valid = 4'b0100;
    push(2'd2, 8'hA2);
    cycle();
    in_valid = 4'b0001;
    #1;
    chk("wrap_ready0", in_ready, 4'b0001);
    push(2'd0, 8'hA0);
    cycle();
    in_valid = 4'b1001;
    #1;
    chk("wrap_ready3", in_ready, 4'b1000);
    push(2'd3, 8'hA3);
    push(2'd0, 8'hA0);
    cycle();
    chk("wrap_ready0b", in_ready, 4'b0001);
    cycle();
    in_valid = '0;
    cycle();
    cycle();
    chk("drain_valid", out_valid, 0);
    chk("drain_data_hold", out_data, 8'hA0);
    chk("drain_sb_empty", sb.size(), 0);

    // Reset while stalled: held beat is discarded, pointer returns to 0.
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    cycle();
    in_valid = '0;
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_sel", out_sel, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    chk("post_rst_ready", in_ready, 4'b0001);
    push(2'd0, 8'hA0);
    cycle();
    in_valid = '0;
    cycle();
    cycle();
    chk("post_rst_sb_empty", sb.size(), 0);

`ifdef MUX_ARB_BURST_EN
    // Burst from requester 1 (ptr is 1); requester 2 waits until the last beat.
    in_valid = 4'b0110;
    in_last  = 4'b0000;
    push(2'd1, 8'hA1);
    push(2'd1, 8'hA1);
    push(2'd1, 8'hA1);
    push(2'd2, 8'hA2);
    cycle();
    chk("burst_lock_ready", in_ready, 4'b0010);
    cycle();
    in_last = 4'b0010;
    #1;
    chk("burst_req2_blocked", in_ready[2], 0);
    cycle();
    in_last  = 4'b0000;
    in_valid = 4'b0100;
    #1;
    chk("burst_release", in_ready, 4'b0100);
    cycle();
    in_valid = '0;
    cycle();
    cycle();
    chk("burst_sb_empty", sb.size(), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
